// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, 8 data bits LSB-first from an
// external serializer, optional even/odd parity bit, and one stop bit.
// One line bit per clk cycle.
//
// Handshake: there is no ready output. A byte is taken on a rising edge where
// data_valid=1 and the frame state is IDLE or STOP. The byte is taken in STOP
// for back-to-back frames. A data_valid seen in START, DATA or PARITY is
// dropped, not queued. busy is high from the cycle after the accept until the
// cycle after the last stop bit.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_done,
    input  logic                  ser_out,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_data,
    output logic                  tx_out,
    output logic                  busy,
    output logic [4:0]            dbg_status
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // DATA is abandoned when the watchdog count reaches this value without
    // ser_done. A stalled serializer therefore cannot hold the line low.
    localparam logic [3:0] WD_LIMIT = 4'd9;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ser_data_q, ser_data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bit_q, par_bit_d;
    logic [3:0]            wd_q, wd_d;
    logic                  accept;

    assign accept = data_valid && ((state_q == IDLE) || (state_q == STOP));

    // Frame state, latched byte, frame configuration and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ser_data_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            wd_q       <= 4'd0;
        end else begin
            state_q    <= state_d;
            ser_data_q <= ser_data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bit_q  <= par_bit_d;
            wd_q       <= wd_d;
        end
    end

    // Next-state logic, accept-time latching and watchdog counting.
    always_comb begin
        state_d    = state_q;
        ser_data_d = ser_data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bit_d  = par_bit_q;
        wd_d       = 4'd0;

        // The parity bit is fixed at accept time. The byte in flight keeps its
        // own parity even when the next byte is latched during STOP.
        if (accept) begin
            ser_data_d = p_data;
            par_en_d   = par_en;
            par_typ_d  = par_typ;
            par_bit_d  = par_typ ? ~^p_data : ^p_data;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                wd_d = wd_q + 4'd1;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else if (wd_q == WD_LIMIT) begin
                    state_d = STOP;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line mux and serializer enable, decoded from the current state only.
    always_comb begin
        tx_out = 1'b1;
        ser_en = 1'b0;
        unique case (state_q)
            IDLE:    tx_out = 1'b1;
            START:   tx_out = 1'b0;
            DATA: begin
                tx_out = ser_out;
                ser_en = 1'b1;
            end
            PARITY:  tx_out = par_bit_q;
            STOP:    tx_out = 1'b1;
            default: tx_out = 1'b1;
        endcase
    end

    assign ser_data   = ser_data_q;
    assign busy       = (state_q != IDLE);
    assign dbg_status = {par_typ_q, par_en_q, state_q};

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: behavioural serializer, table vectors, random frames
// against a bit-queue frame model, and hand sequences for corner cases.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       ser_done;
    logic       ser_out;
    logic       ser_en;
    logic [7:0] ser_data;
    logic       tx_out;
    logic       busy;
    logic [4:0] dbg_status;

    int checks   = 0;
    int failures = 0;

    logic       got_q[$];
    logic [0:0] exp_q[$];
    int         en_cnt;
    logic       suppress_done;

    // Behavioural 8-bit serializer: reloads while ser_en=0, shifts LSB-first.
    logic [7:0] sr;
    int         sr_cnt;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .ser_done(ser_done),
        .ser_out(ser_out), .ser_en(ser_en), .ser_data(ser_data),
        .tx_out(tx_out), .busy(busy), .dbg_status(dbg_status)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr     <= 8'd0;
            sr_cnt <= 0;
        end else if (!ser_en) begin
            sr     <= ser_data;
            sr_cnt <= 0;
        end else begin
            sr     <= sr >> 1;
            sr_cnt <= sr_cnt + 1;
        end
    end
    assign ser_out  = sr[0];
    assign ser_done = ser_en && (sr_cnt == 7) && !suppress_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB-first, parity making the total count
    // of ones even (even) or odd (odd), stop 1.
    function automatic void model_frame(input logic [7:0] d, input logic pe, input logic pt);
        int ones;
        ones = $countones(d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) begin
            if (pt) exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
            else    exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        end
        exp_q.push_back(1'b1);
    endfunction

    // Drive one accept; returns at the first sample point of frame cycle 1.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    // Record tx_out for every busy cycle. pulse_at >= 0 pulses data_valid with a
    // different byte in that frame cycle.
    task automatic capture(input int pulse_at, input int max_cyc);
        int n;
        n = 0;
        en_cnt = 0;
        got_q.delete();
        while (busy === 1'b1 && n < max_cyc) begin
            got_q.push_back(tx_out);
            if (ser_en) en_cnt++;
            if (n == pulse_at) begin
                data_valid = 1'b1;
                p_data     = 8'hAA;
            end else begin
                data_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        data_valid = 1'b0;
        check("frame_end_busy", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx_out), 32'd1);
    endtask

    task automatic cmp_frames(input string name);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({name, "_bit"}, 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        logic       rpe;
        logic       rpt;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       busy_all;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 10};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 11};

        // reset
        rst = 1'b0; p_data = 8'h00; data_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; suppress_done = 1'b0;
        #1;
        check("rst_tx", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ser_en", 32'(ser_en), 32'd0);
        check("rst_ser_data", 32'(ser_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_tx", 32'(tx_out), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ser_en", 32'(ser_en), 32'd0);
        end

        // table vectors
        for (int v = 0; v < 6; v++) begin
            model_frame(vecs[v].d, vecs[v].pe, vecs[v].pt);
            start_frame(vecs[v].d, vecs[v].pe, vecs[v].pt);
            capture(-1, 20);
            check("vec_len", 32'(got_q.size()), 32'(vecs[v].exp_len));
            check("vec_ser_en_cycles", 32'(en_cnt), 32'd8);
            if (vecs[v].pe && got_q.size() > 9)
                check("vec_parity", 32'(got_q[9]), 32'(vecs[v].exp_par));
            cmp_frames("vec");
        end

        // data_valid pulse and p_data change during DATA are ignored
        model_frame(8'h55, 1'b1, 1'b0);
        start_frame(8'h55, 1'b1, 1'b0);
        capture(4, 20);
        cmp_frames("ignore_dv");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ignore_dv_no_second", 32'(busy), 32'd0);
        end

        // back-to-back: data_valid held through frame 1's STOP
        model_frame(8'h3C, 1'b1, 1'b0);
        model_frame(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        @(posedge clk); #1;
        p_data = 8'hC3;
        got_q.delete();
        busy_all = 1'b1;
        for (int n = 0; n < 22; n++) begin
            got_q.push_back(tx_out);
            busy_all = busy_all & busy;
            if (n == 11) data_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_busy_held", 32'(busy_all), 32'd1);
        check("b2b_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            b1[i] = got_q[1 + i];
            b2[i] = got_q[12 + i];
        end
        check("b2b_rx_byte1", 32'(b1), 32'h3C);
        check("b2b_rx_byte2", 32'(b2), 32'hC3);
        cmp_frames("b2b");

        // reset in frame cycle 5, then a clean frame
        start_frame(8'h96, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx_out), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ser_en", 32'(ser_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_frame(8'hFF, 1'b1, 1'b1);
        start_frame(8'hFF, 1'b1, 1'b1);
        capture(-1, 20);
        cmp_frames("after_rst");

        // stalled serializer: the watchdog must end the frame with a high line
        suppress_done = 1'b1;
        start_frame(8'h00, 1'b1, 1'b0);
        capture(-1, 20);
        check("wd_start_bit", 32'(got_q[0]), 32'd0);
        check("wd_last_bit", 32'(got_q[got_q.size() - 1]), 32'd1);
        suppress_done = 1'b0;

        // randomized frames against the model
        for (int k = 0; k < 24; k++) begin
            rd  = 8'($urandom_range(0, 255));
            rpe = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            model_frame(rd, rpe, rpt);
            start_frame(rd, rpe, rpt);
            capture(-1, 20);
            cmp_frames("rand");
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
